// File: rtl/io_seg_scan.sv
// ---------------------------------------------------------------------------
// io_seg_scan
//
// Eight-digit multiplexed seven-segment scanner for a common-anode hex
// display. Captures one of the CPU output ports into a shadow register on a
// load strobe, optionally computes leading-zero blanking for that value, and
// walks the eight hex nibbles across the digit anodes at a programmable rate.
//
// Parameters
//   SCAN_DIV  clock cycles each digit stays lit (2 .. 2^20)
//
// Ports
//   clock     system clock, rising edge
//   clrn      synchronous active-low reset
//   port0     value from out_port0
//   port1     value from out_port1
//   sel       load source select (0 = port0, 1 = port1)
//   load      capture selected port (and lzb) into the shadow register
//   lzb       leading-zero blanking enable, sampled with load
//   dp_mask   per-digit decimal point enables (1 = lit), used live
//   an        digit anodes, active low, bit i = digit i (nibble [4i+3:4i])
//   seg       segments {g,f,e,d,c,b,a}, active low
//   dp        decimal point, active low
// ---------------------------------------------------------------------------
module io_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] port0,
    input  logic [31:0] port1,
    input  logic        sel,
    input  logic        load,
    input  logic        lzb,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned NUM_DIGITS = 8;
    // SCAN_DIV >= 2 keeps this at least one bit wide.
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

    // Active-low seven-segment pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // State
    logic [PW-1:0]  pcnt_q,   pcnt_d;
    logic [2:0]     idx_q,    idx_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [7:0]     blank_q,  blank_d;
    logic [7:0]     an_q,     an_d;
    logic [6:0]     seg_q,    seg_d;
    logic           dp_q,     dp_d;

    logic           tick;
    logic [31:0]    load_val;
    logic [NUM_DIGITS-1:0][3:0] load_nib;
    logic [NUM_DIGITS-1:0][3:0] shadow_nib;
    logic [NUM_DIGITS-1:0]      zero_from;  // nibbles i..7 of load_val all zero
    logic [NUM_DIGITS-1:0]      blank_new;
    logic [3:0]     cur_nib;

    assign tick     = (pcnt_q == PCNT_LAST);
    assign load_val = sel ? port1 : port0;

    // Per-digit views of the incoming and stored values, and the blanking
    // chain that runs from the most significant nibble downwards.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign load_nib[i]   = load_val[4*i +: 4];
        assign shadow_nib[i] = shadow_q[4*i +: 4];

        if (i == NUM_DIGITS - 1) begin : g_top
            assign zero_from[i] = (load_nib[i] == 4'h0);
        end else begin : g_chain
            assign zero_from[i] = zero_from[i+1] & (load_nib[i] == 4'h0);
        end

        // Digit 0 always shows something, so a zero value displays "0".
        if (i == 0) begin : g_d0
            assign blank_new[i] = 1'b0;
        end else begin : g_dn
            assign blank_new[i] = lzb & zero_from[i];
        end
    end

    // Prescaler and digit index.
    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        idx_d  = tick ? idx_q + 3'd1 : idx_q;   // 3-bit wrap 7 -> 0
    end

    // Shadow capture; blanking is derived from the incoming value.
    always_comb begin
        shadow_d = shadow_q;
        blank_d  = blank_q;
        if (load) begin
            shadow_d = load_val;
            blank_d  = blank_new;
        end
    end

    // Output stage reads the registered index/shadow, so a load or a digit
    // step shows up one edge later with anodes and segments moving together.
    always_comb begin
        cur_nib = shadow_nib[idx_q];
        an_d    = ~(8'd1 << idx_q);
        seg_d   = blank_q[idx_q] ? 7'h7F : hex7(cur_nib);
        dp_d    = ~dp_mask[idx_q];
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            blank_q  <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            blank_q  <= blank_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_io_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_io_seg_scan
//
// Scoreboarded bench for io_seg_scan with SCAN_DIV = 4. Every clock edge the
// driver predicts the display from a time-based model (digit shown = edges
// since reset / SCAN_DIV mod 8, value = last loaded word) and queues it; a
// monitor on the falling edge pops and compares an/seg/dp.
// ---------------------------------------------------------------------------
module tb_io_seg_scan;

    localparam int SD = 4;

    logic        clock = 1'b0;
    logic        clrn;
    logic [31:0] port0, port1;
    logic        sel, load, lzb;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clock = ~clock;

    io_seg_scan #(.SCAN_DIV(SD)) dut (
        .clock   (clock),
        .clrn    (clrn),
        .port0   (port0),
        .port1   (port1),
        .sel     (sel),
        .load    (load),
        .lzb     (lzb),
        .dp_mask (dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    string       phase = "init";

    // Reference model state
    logic [31:0] m_val = 32'h0;
    bit          m_lzb = 1'b0;
    int          m_cnt = 0;     // edges since reset released

    logic [6:0] hex_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                   7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                   7'h46, 7'h21, 7'h06, 7'h0E};

    // Predict the outputs for the coming edge, advance the model, clock once.
    task automatic cyc();
        logic [15:0] e;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [31:0] upper;
        int          d;
        bit          blanked;
        if (!clrn) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            d       = (m_cnt / SD) % 8;
            upper   = m_val >> (4 * d);
            blanked = m_lzb && (d != 0) && (upper == 32'h0);
            e_an    = ~(8'd1 << d);
            e_seg   = blanked ? 7'h7F : hex_tab[4'(upper)];
            e_dp    = ~dp_mask[d];
        end
        e = {e_an, e_seg, e_dp};
        if (!clrn) begin
            m_val = 32'h0; m_lzb = 1'b0; m_cnt = 0;
        end else begin
            m_cnt++;
            if (load) begin
                m_val = sel ? port1 : port0;
                m_lzb = lzb;
            end
        end
        @(posedge clock);
        exp_q.push_back(e);
        tag_q.push_back(phase);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input bit s, input logic [31:0] v, input bit z);
        sel = s; lzb = z; load = 1'b1;
        if (s) port1 = v; else port0 = v;
        cyc();
        load = 1'b0;
    endtask

    // Run until the model sits at a given position within the 8*SD frame.
    task automatic align(input int pos);
        for (int i = 0; i < 8 * SD && (m_cnt % (8 * SD)) != pos; i++) cyc();
    endtask

    // Monitor: compare every registered output against the queued prediction.
    always @(negedge clock) begin
        logic [15:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if ({an, seg, dp} !== e) begin
                n_fail++;
                $display("FAIL %s: an/seg/dp got %h/%h/%b expected %h/%h/%b",
                         t, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
        end
    end

    initial begin
        clrn = 1'b0; load = 1'b0; sel = 1'b0; lzb = 1'b0;
        port0 = 32'h0; port1 = 32'h0; dp_mask = 8'h00;

        // Reset with random inputs toggling underneath.
        phase = "reset";
        for (int i = 0; i < 3; i++) begin
            port0 = $urandom; port1 = $urandom; sel = 1'($urandom);
            load = 1'($urandom); lzb = 1'($urandom); dp_mask = 8'($urandom);
            cyc();
        end
        clrn = 1'b1; load = 1'b0; dp_mask = 8'h00;
        phase = "release";
        run(6);

        phase = "full_scan";
        do_load(1'b0, 32'h89ABCDEF, 1'b0);
        run(8 * SD + 8);

        phase = "lzb_a05";
        do_load(1'b1, 32'h00000A05, 1'b1);
        run(8 * SD + 4);
        phase = "lzb_zero";
        do_load(1'b1, 32'h00000000, 1'b1);
        run(8 * SD + 4);

        // Load exactly on the edge where the index steps 3 -> 4.
        phase = "load_tick";
        align(4 * SD - 1);
        do_load(1'b0, 32'h000F0000, 1'b0);
        run(2 * SD);

        phase = "dp_mask";
        dp_mask = 8'h81;
        do_load(1'b0, 32'h00000001, 1'b1);
        run(8 * SD + 4);

        // One-cycle reset while digit 5 is lit.
        phase = "mid_reset";
        dp_mask = 8'h00;
        do_load(1'b0, 32'h89ABCDEF, 1'b0);
        align(5 * SD + 1);
        clrn = 1'b0;
        cyc();
        clrn = 1'b1;
        run(3 * SD);

        // Random traffic: sparse loads, small values to exercise blanking,
        // occasional resets, live dp_mask changes.
        phase = "random";
        for (int i = 0; i < 800; i++) begin
            port0   = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(4, 31));
            port1   = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(4, 31));
            sel     = 1'($urandom);
            lzb     = 1'($urandom);
            load    = ($urandom_range(0, 7) == 0);
            dp_mask = 8'($urandom);
            clrn    = ($urandom_range(0, 63) != 0);
            cyc();
        end
        clrn = 1'b1; load = 1'b0;

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
